// File: rtl/tpu_dma_pkg.sv
// Shared types and constants for the host-side DMA initiator and its watchdog.
// Widths here match the tpu_top DMA port.
package tpu_dma_pkg;

    localparam int DMA_DATA_W     = 256;
    localparam int UB_ADDR_W      = 8;
    localparam int DMA_BEAT_BYTES = DMA_DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_WDATA,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_RD_HOLD,
        ST_FINISH
    } dma_host_state_t;

    typedef enum logic [1:0] {
        ELEM_8B   = 2'b00,
        ELEM_16B  = 2'b01,
        ELEM_32B  = 2'b10,
        ELEM_RSVD = 2'b11
    } elem_sz_t;

endpackage

// File: rtl/dma_watchdog.sv
// Loadable countdown: clr_i reloads, en_i decrements, expire_o flags an enabled
// cycle with the count already at zero.
module dma_watchdog #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] load_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = load_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/tpu_dma_host.sv
// Host-side DMA initiator: splits a command into single-beat tpu_top DMA
// transactions, streaming write beats in and read beats out.
module tpu_dma_host
    import tpu_dma_pkg::*;
#(
    parameter int DATA_W  = DMA_DATA_W,
    parameter int ADDR_W  = UB_ADDR_W,
    parameter int LEN_W   = 16,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [ADDR_W-1:0] cmd_ub_addr,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic [1:0]        cmd_elem_sz,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              xfer_done,
    output logic              xfer_err,
    output logic              dma_start,
    output logic              dma_dir,
    output logic [ADDR_W-1:0] dma_ub_addr,
    output logic [LEN_W-1:0]  dma_length,
    output logic [1:0]        dma_elem_sz,
    output logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_busy,
    input  logic              dma_done,
    input  logic [DATA_W-1:0] dma_rdata
);

    localparam int WD_W = $clog2(TIMEOUT);

    dma_host_state_t   state_q, state_d;
    logic              dir_q, dir_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [1:0]        elem_q, elem_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              wd_clr, wd_en, wd_expire, abort;

    // Reloaded at every start so that it counts down only the current beat's wait.
    dma_watchdog #(.W(WD_W)) u_wd (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .load_i   (WD_W'(TIMEOUT - 1)),
        .expire_o (wd_expire)
    );

    assign wd_en = (state_q == ST_WAIT_DONE);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        elem_d  = elem_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wd_clr  = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    dir_d  = cmd_dir;
                    addr_d = cmd_ub_addr;
                    rem_d  = cmd_count;
                    elem_d = cmd_elem_sz;
                    err_d  = 1'b0;
                    if (cmd_count == '0)  state_d = ST_FINISH;
                    else if (cmd_dir)     state_d = ST_ISSUE;
                    else                  state_d = ST_WAIT_WDATA;
                end
            end
            ST_WAIT_WDATA: begin
                if (wr_valid) begin
                    wdata_d = wr_data;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!dma_busy) begin
                    wd_clr  = 1'b1;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // A completion in the expiry cycle still counts as success.
                if (dma_done) begin
                    if (dir_q) begin
                        rdata_d = dma_rdata;
                        state_d = ST_RD_HOLD;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        rem_d   = rem_q - CNT_W'(1);
                        state_d = (rem_q == CNT_W'(1)) ? ST_FINISH : ST_WAIT_WDATA;
                    end
                end else if (wd_expire) begin
                    abort   = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RD_HOLD: begin
                if (rd_ready) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    rem_d   = rem_q - CNT_W'(1);
                    state_d = (rem_q == CNT_W'(1)) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            elem_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            elem_q  <= elem_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign wr_ready    = (state_q == ST_WAIT_WDATA);
    assign rd_valid    = (state_q == ST_RD_HOLD);
    assign rd_data     = rdata_q;
    assign xfer_done   = (state_q == ST_FINISH) || abort;
    assign xfer_err    = err_q || abort;
    assign dma_start   = (state_q == ST_ISSUE) && !dma_busy;
    assign dma_dir     = dir_q;
    assign dma_ub_addr = addr_q;
    assign dma_length  = LEN_W'(DATA_W / 8);
    assign dma_elem_sz = elem_q;
    assign dma_wdata   = wdata_q;

endmodule

// File: tb/tb_tpu_dma_host.sv
// Directed bench for tpu_dma_host with a behavioural tpu_top DMA responder.
module tb_tpu_dma_host;

    localparam int DW = 256;
    localparam int AW = 8;
    localparam int LW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_dir;
    logic [AW-1:0] cmd_ub_addr;
    logic [CW-1:0] cmd_count;
    logic [1:0]    cmd_elem_sz;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready;
    logic [DW-1:0] rd_data;
    logic          xfer_done, xfer_err;
    logic          dma_start, dma_dir;
    logic [AW-1:0] dma_ub_addr;
    logic [LW-1:0] dma_length;
    logic [1:0]    dma_elem_sz;
    logic [DW-1:0] dma_wdata;
    logic          dma_busy, dma_done;
    logic [DW-1:0] dma_rdata;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    logic [AW-1:0] st_addr[$];
    logic [LW-1:0] st_len[$];
    logic [DW-1:0] st_wdata[$];
    logic          st_dir[$];
    logic [1:0]    st_esz[$];
    bit            resp_en = 1'b1;
    int            resp_lat = 2;
    logic [DW-1:0] rd_vals[$];
    int            rsp_cd = 0;
    int            rsp_ridx = 0;
    logic          rsp_st;

    tpu_dma_host #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .CNT_W(CW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_ub_addr(cmd_ub_addr), .cmd_count(cmd_count), .cmd_elem_sz(cmd_elem_sz),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .xfer_done(xfer_done), .xfer_err(xfer_err),
        .dma_start(dma_start), .dma_dir(dma_dir), .dma_ub_addr(dma_ub_addr),
        .dma_length(dma_length), .dma_elem_sz(dma_elem_sz), .dma_wdata(dma_wdata),
        .dma_busy(dma_busy), .dma_done(dma_done), .dma_rdata(dma_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not complete");
    end

    // Monitor: logs every start pulse and counts xfer_done pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (dma_start === 1'b1) begin
                st_addr.push_back(dma_ub_addr);
                st_len.push_back(dma_length);
                st_wdata.push_back(dma_wdata);
                st_dir.push_back(dma_dir);
                st_esz.push_back(dma_elem_sz);
            end
            if (xfer_done === 1'b1) n_done++;
        end
    end

    // Responder: dma_done resp_lat cycles after a start, read data from rd_vals.
    initial begin
        dma_done  = 1'b0;
        dma_rdata = '0;
        forever begin
            @(negedge clk);
            rsp_st = dma_start;
            @(posedge clk);
            #1;
            dma_done = 1'b0;
            if (rsp_cd > 0) begin
                rsp_cd--;
                if (rsp_cd == 0) begin
                    dma_done = 1'b1;
                    if (dma_dir && rsp_ridx < rd_vals.size()) begin
                        dma_rdata = rd_vals[rsp_ridx];
                        rsp_ridx++;
                    end
                end
            end
            if (rsp_st === 1'b1 && resp_en) rsp_cd = resp_lat - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic dir, input logic [AW-1:0] addr,
                            input logic [CW-1:0] cnt, input logic [1:0] esz);
        cmd_valid = 1'b1; cmd_dir = dir; cmd_ub_addr = addr;
        cmd_count = cnt;  cmd_elem_sz = esz;
        @(negedge clk);
        chk("cmd_ready", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wr_beat(input logic [DW-1:0] d);
        int n = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        while (wr_ready !== 1'b1 && n < 100) begin
            tick(); @(negedge clk); n++;
        end
        chk("wr_ready_seen", 32'(wr_ready), 1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_rd_valid();
        int n = 0;
        @(negedge clk);
        while (rd_valid !== 1'b1 && n < 100) begin
            tick(); @(negedge clk); n++;
        end
        chk("rd_valid_seen", 32'(rd_valid), 1);
    endtask

    task automatic wait_start();
        int n = 0;
        @(negedge clk);
        while (dma_start !== 1'b1 && n < 100) begin
            tick(); @(negedge clk); n++;
        end
        chk("start_seen", 32'(dma_start), 1);
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (n_done <= base && n < 100) begin
            tick(); n++;
        end
        chk("xfer_done_seen", 32'(n_done > base), 1);
    endtask

    initial begin
        int b;
        int t;
        cmd_valid = 0; cmd_dir = 0; cmd_ub_addr = '0; cmd_count = '0; cmd_elem_sz = '0;
        wr_valid = 0; wr_data = '0; rd_ready = 0; dma_busy = 0; rst = 1;
        tick(); tick();
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chkw("rst_rd_data", rd_data, '0);
        chk("rst_xfer_done", 32'(xfer_done), 0);
        chk("rst_xfer_err", 32'(xfer_err), 0);
        chk("rst_dma_start", 32'(dma_start), 0);
        chk("rst_dma_addr", 32'(dma_ub_addr), 0);
        chkw("rst_dma_wdata", dma_wdata, '0);
        rst = 0;
        tick();

        // 4-beat write from 0x10
        b = st_addr.size(); t = n_done;
        send_cmd(1'b0, 8'h10, 8'd4, 2'b01);
        for (int i = 0; i < 4; i++) wr_beat(DW'((i + 1) << 8));
        wait_done(t);
        repeat (5) tick();
        chk("wr_starts", 32'(st_addr.size() - b), 4);
        for (int i = 0; i < 4; i++) begin
            chk("wr_addr", 32'(st_addr[b+i]), 'h10 + i);
            chk("wr_len", 32'(st_len[b+i]), 32);
            chkw("wr_wdata", st_wdata[b+i], DW'((i + 1) << 8));
            chk("wr_esz", 32'(st_esz[b+i]), 1);
            chk("wr_dir", 32'(st_dir[b+i]), 0);
        end
        chk("wr_single_done", 32'(n_done - t), 1);
        chk("wr_err", 32'(xfer_err), 0);

        // 2-beat read with host stalling the first beat
        rd_vals.push_back(DW'('h57));
        rd_vals.push_back(DW'('h77));
        b = st_addr.size(); t = n_done;
        send_cmd(1'b1, 8'h20, 8'd2, 2'b00);
        wait_rd_valid();
        for (int i = 0; i < 5; i++) begin
            chk("rd_hold_valid", 32'(rd_valid), 1);
            chkw("rd_hold_data", rd_data, DW'('h57));
            chk("rd_hold_no_start", 32'(dma_start), 0);
            tick(); @(negedge clk);
        end
        chk("rd_starts_before_hs", 32'(st_addr.size() - b), 1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        wait_rd_valid();
        chkw("rd_data1", rd_data, DW'('h77));
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        wait_done(t);
        chk("rd_starts", 32'(st_addr.size() - b), 2);
        chk("rd_addr0", 32'(st_addr[b]), 'h20);
        chk("rd_addr1", 32'(st_addr[b+1]), 'h21);
        chk("rd_dir", 32'(st_dir[b]), 1);

        // Address wrap
        b = st_addr.size(); t = n_done;
        send_cmd(1'b0, 8'hFE, 8'd3, 2'b10);
        wr_beat(DW'('hA)); wr_beat(DW'('hB)); wr_beat(DW'('hC));
        wait_done(t);
        chk("wrap_addr0", 32'(st_addr[b]), 'hFE);
        chk("wrap_addr1", 32'(st_addr[b+1]), 'hFF);
        chk("wrap_addr2", 32'(st_addr[b+2]), 'h00);

        // Busy stall at ISSUE
        dma_busy = 1'b1;
        b = st_addr.size(); t = n_done;
        send_cmd(1'b0, 8'h30, 8'd1, 2'b00);
        wr_beat(DW'('h55));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("busy_no_start", 32'(dma_start), 0);
            tick();
        end
        dma_busy = 1'b0;
        @(negedge clk);
        chk("busy_start", 32'(dma_start), 1);
        wait_done(t);
        repeat (3) tick();
        chk("busy_one_start", 32'(st_addr.size() - b), 1);
        chk("busy_addr", 32'(st_addr[b]), 'h30);

        // Zero-count command
        b = st_addr.size(); t = n_done;
        send_cmd(1'b0, 8'h44, 8'd0, 2'b00);
        @(negedge clk);
        chk("zero_done", 32'(xfer_done), 1);
        tick(); @(negedge clk);
        chk("zero_done_pulse", 32'(xfer_done), 0);
        chk("zero_idle", 32'(cmd_ready), 1);
        chk("zero_no_start", 32'(st_addr.size() - b), 0);
        tick();

        // Timeout: responder silent, 16 cycles from start to abort
        resp_en = 1'b0;
        b = st_addr.size();
        send_cmd(1'b0, 8'h60, 8'd2, 2'b00);
        wr_beat(DW'('h99));
        wait_start();
        for (int k = 1; k < 16; k++) begin
            tick(); @(negedge clk);
            chk("to_no_done", 32'(xfer_done), 0);
        end
        tick(); @(negedge clk);
        chk("to_done", 32'(xfer_done), 1);
        chk("to_err", 32'(xfer_err), 1);
        tick(); @(negedge clk);
        chk("to_done_pulse", 32'(xfer_done), 0);
        chk("to_err_sticky", 32'(xfer_err), 1);
        chk("to_idle", 32'(cmd_ready), 1);
        chk("to_dropped", 32'(st_addr.size() - b), 1);
        tick();
        resp_en = 1'b1;
        send_cmd(1'b0, 8'h00, 8'd0, 2'b00);
        @(negedge clk);
        chk("err_cleared", 32'(xfer_err), 0);
        tick();

        // Reset during WAIT_DONE of a 4-beat write
        resp_en = 1'b0;
        b = st_addr.size(); t = n_done;
        send_cmd(1'b0, 8'h40, 8'd4, 2'b10);
        wr_beat(DW'('hAA));
        wait_start();
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_cmd_ready", 32'(cmd_ready), 1);
        chk("mrst_start", 32'(dma_start), 0);
        chk("mrst_done", 32'(xfer_done), 0);
        chk("mrst_wr_ready", 32'(wr_ready), 0);
        chk("mrst_addr", 32'(dma_ub_addr), 0);
        chk("mrst_esz", 32'(dma_elem_sz), 0);
        chkw("mrst_wdata", dma_wdata, '0);
        repeat (20) tick();
        chk("mrst_no_done", 32'(n_done - t), 0);
        chk("mrst_no_start", 32'(st_addr.size() - b), 1);
        resp_en = 1'b1;
        b = st_addr.size(); t = n_done;
        send_cmd(1'b0, 8'h50, 8'd2, 2'b00);
        wr_beat(DW'('h1111)); wr_beat(DW'('h2222));
        wait_done(t);
        chk("post_starts", 32'(st_addr.size() - b), 2);
        chk("post_addr0", 32'(st_addr[b]), 'h50);
        chk("post_addr1", 32'(st_addr[b+1]), 'h51);
        chkw("post_wdata1", st_wdata[b+1], DW'('h2222));
        chk("post_err", 32'(xfer_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
